// File: rtl/cpu_clock_monitor_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_clock_monitor_pkg
// Description : Shared types and default constants for the NES CPU/PPU clock
//               monitor: FSM state encoding, edge-count width, default gate
//               window / settle / expectation values, and the absolute
//               deviation helper used for the frequency verdict.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_clock_monitor_pkg;

    // Width of the per-window edge counters and reported counts.
    localparam int c_CNT_W = 16;

    // Defaults for a 50 MHz reference and a 1 ms gate window.
    localparam int c_WINDOW_CYCLES = 50000;
    localparam int c_SETTLE_CYCLES = 1024;
    localparam int c_EXP0          = 1790;
    localparam int c_EXP1          = 5369;
    localparam int c_TOL           = 8;

    localparam logic [c_CNT_W-1:0] c_CNT_MAX = '1;

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        SETTLE    = 2'd1,
        MEASURE   = 2'd2,
        REPORT    = 2'd3
    } state_e;

    // |cnt - exp_val| <= tol, evaluated with one extra bit so the difference
    // of two 16-bit unsigned values never wraps.
    function automatic logic within_tol(
        input logic [c_CNT_W-1:0] cnt,
        input logic [c_CNT_W-1:0] exp_val,
        input logic [c_CNT_W-1:0] tol
    );
        logic [c_CNT_W:0] w_diff;
        logic [c_CNT_W:0] w_mag;
        w_diff = {1'b0, cnt} - {1'b0, exp_val};
        w_mag  = w_diff[c_CNT_W] ? (~w_diff + 1'b1) : w_diff;
        return (w_mag <= {1'b0, tol});
    endfunction

endpackage : cpu_clock_monitor_pkg
`default_nettype wire

// File: rtl/clkmon_edge_sync.sv
`default_nettype none
// ============================================================================
// Module      : clkmon_edge_sync
// Description : Two-flop synchroniser for an asynchronous clock-like input,
//               followed by a third flop for rising-edge detection.
//               o_rise is a one-cycle pulse in the clk domain, asserted two
//               clk cycles after the input is first sampled high.
// Ports       : clk     - sampling clock
//               rst     - synchronous active-high reset
//               i_async - asynchronous input
//               o_rise  - rising-edge pulse (s2 & ~s3)
// Revision    : 1.0 - initial release
// ============================================================================
module clkmon_edge_sync
    import cpu_clock_monitor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic i_async,
    output logic o_rise
);

    logic r_s1_q, r_s2_q, r_s3_q;
    logic w_s1_d, w_s2_d, w_s3_d;

    always_comb begin
        w_s1_d = i_async;
        w_s2_d = r_s1_q;
        w_s3_d = r_s2_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_q <= 1'b0;
            r_s2_q <= 1'b0;
            r_s3_q <= 1'b0;
        end else begin
            r_s1_q <= w_s1_d;
            r_s2_q <= w_s2_d;
            r_s3_q <= w_s3_d;
        end
    end

    assign o_rise = r_s2_q & ~r_s3_q;

endmodule : clkmon_edge_sync
`default_nettype wire

// File: rtl/cpu_clock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : cpu_clock_monitor
// Description : Frequency and lock monitor for the NES CPU/PPU PLL clocks.
//               Runs in the refclk domain, counts rising edges of both PLL
//               outputs over back-to-back gate windows, reports counts with a
//               tolerance verdict, and keeps a sticky lock-loss flag.
// Config      : CPU_CLKMON_RATIO_CHECK_EN - when defined, ratio_ok checks
//               |count1 - 3*count0| <= 3*TOL each window; otherwise ratio_ok
//               is tied high.
// Ports       : refclk     - 50 MHz reference, the only clock
//               rst        - synchronous active-high reset
//               clk0_in    - PLL outclk_0 (CPU clock), asynchronous
//               clk1_in    - PLL outclk_1 (PPU clock), asynchronous
//               locked_in  - PLL locked flag, asynchronous
//               clear_err  - pulse clearing lock_lost
//               count0/1   - edges counted in last completed window
//               meas_valid - one-cycle pulse when counts/verdicts update
//               freq_ok    - both counts within TOL of expectation
//               ratio_ok   - 3:1 ratio verdict
//               lock_lost  - sticky lock-drop flag
//               measuring  - high in SETTLE or MEASURE
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_clock_monitor
    import cpu_clock_monitor_pkg::*;
#(
    parameter int WINDOW_CYCLES = c_WINDOW_CYCLES,
    parameter int SETTLE_CYCLES = c_SETTLE_CYCLES,
    parameter int EXP0          = c_EXP0,
    parameter int EXP1          = c_EXP1,
    parameter int TOL           = c_TOL
) (
    input  logic               refclk,
    input  logic               rst,
    input  logic               clk0_in,
    input  logic               clk1_in,
    input  logic               locked_in,
    input  logic               clear_err,
    output logic [c_CNT_W-1:0] count0,
    output logic [c_CNT_W-1:0] count1,
    output logic               meas_valid,
    output logic               freq_ok,
    output logic               ratio_ok,
    output logic               lock_lost,
    output logic               measuring
);

    // One phase counter serves both the settle delay and the gate window.
    localparam int c_PH_MAX = (WINDOW_CYCLES > SETTLE_CYCLES) ? WINDOW_CYCLES : SETTLE_CYCLES;
    localparam int c_PH_W   = (c_PH_MAX > 2) ? $clog2(c_PH_MAX) : 1;

    localparam logic [c_PH_W-1:0]  c_WIN_LAST = c_PH_W'(WINDOW_CYCLES - 1);
    localparam logic [c_PH_W-1:0]  c_SET_LAST = c_PH_W'(SETTLE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_EXP0_V   = c_CNT_W'(EXP0);
    localparam logic [c_CNT_W-1:0] c_EXP1_V   = c_CNT_W'(EXP1);
    localparam logic [c_CNT_W-1:0] c_TOL_V    = c_CNT_W'(TOL);

    // ---------------------------------------------------------------- inputs
    logic w_rise0, w_rise1;

    clkmon_edge_sync u_sync_clk0 (
        .clk     (refclk),
        .rst     (rst),
        .i_async (clk0_in),
        .o_rise  (w_rise0)
    );

    clkmon_edge_sync u_sync_clk1 (
        .clk     (refclk),
        .rst     (rst),
        .i_async (clk1_in),
        .o_rise  (w_rise1)
    );

    // The lock flag only needs the level, so it gets a plain 2-FF chain.
    logic r_lock_s1_q, r_lock_s2_q;
    logic w_lock_s1_d, w_lock_s2_d;

    always_comb begin
        w_lock_s1_d = locked_in;
        w_lock_s2_d = r_lock_s1_q;
    end

    // ---------------------------------------------------------------- state
    state_e             r_state_q,      w_state_d;
    logic [c_PH_W-1:0]  r_phase_q,      w_phase_d;
    logic [c_CNT_W-1:0] r_cnt0_q,       w_cnt0_d;
    logic [c_CNT_W-1:0] r_cnt1_q,       w_cnt1_d;
    logic [c_CNT_W-1:0] r_count0_q,     w_count0_d;
    logic [c_CNT_W-1:0] r_count1_q,     w_count1_d;
    logic               r_meas_valid_q, w_meas_valid_d;
    logic               r_freq_ok_q,    w_freq_ok_d;
    logic               r_lock_lost_q,  w_lock_lost_d;
    logic               r_measuring_q,  w_measuring_d;
    logic               w_abort;

`ifdef CPU_CLKMON_RATIO_CHECK_EN
    localparam int              c_RW        = c_CNT_W + 3;
    localparam logic [c_RW-1:0] c_RATIO_TOL = c_RW'(3 * TOL);

    logic r_ratio_ok_q, w_ratio_ok_d;

    // |c1 - 3*c0| <= 3*TOL with enough headroom for 3*0xFFFF.
    function automatic logic ratio_within(
        input logic [c_CNT_W-1:0] c0,
        input logic [c_CNT_W-1:0] c1
    );
        logic [c_RW-1:0] w_c0x3;
        logic [c_RW-1:0] w_diff;
        logic [c_RW-1:0] w_mag;
        w_c0x3 = ({3'b000, c0} << 1) + {3'b000, c0};
        w_diff = {3'b000, c1} - w_c0x3;
        w_mag  = w_diff[c_RW-1] ? (~w_diff + 1'b1) : w_diff;
        return (w_mag <= c_RATIO_TOL);
    endfunction
`endif

    always_comb begin
        w_state_d      = r_state_q;
        w_phase_d      = r_phase_q;
        w_cnt0_d       = r_cnt0_q;
        w_cnt1_d       = r_cnt1_q;
        w_count0_d     = r_count0_q;
        w_count1_d     = r_count1_q;
        w_meas_valid_d = 1'b0;
        w_freq_ok_d    = r_freq_ok_q;
        w_lock_lost_d  = clear_err ? 1'b0 : r_lock_lost_q;
        w_abort        = 1'b0;
`ifdef CPU_CLKMON_RATIO_CHECK_EN
        w_ratio_ok_d   = r_ratio_ok_q;
`endif

        case (r_state_q)
            WAIT_LOCK: begin
                w_phase_d = '0;
                w_cnt0_d  = '0;
                w_cnt1_d  = '0;
                if (r_lock_s2_q) begin
                    w_state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (!r_lock_s2_q) begin
                    w_abort = 1'b1;
                end else if (r_phase_q == c_SET_LAST) begin
                    w_phase_d = '0;
                    w_state_d = MEASURE;
                end else begin
                    w_phase_d = r_phase_q + 1'b1;
                end
            end
            MEASURE: begin
                if (!r_lock_s2_q) begin
                    w_abort = 1'b1;
                end else begin
                    // Edges on the final window cycle still land in this window.
                    if (w_rise0 && (r_cnt0_q != c_CNT_MAX)) begin
                        w_cnt0_d = r_cnt0_q + 1'b1;
                    end
                    if (w_rise1 && (r_cnt1_q != c_CNT_MAX)) begin
                        w_cnt1_d = r_cnt1_q + 1'b1;
                    end
                    if (r_phase_q == c_WIN_LAST) begin
                        w_phase_d = '0;
                        w_state_d = REPORT;
                    end else begin
                        w_phase_d = r_phase_q + 1'b1;
                    end
                end
            end
            REPORT: begin
                if (!r_lock_s2_q) begin
                    w_abort = 1'b1;
                end else begin
                    // Edges seen during this gap cycle are discarded by the clear.
                    w_count0_d     = r_cnt0_q;
                    w_count1_d     = r_cnt1_q;
                    w_meas_valid_d = 1'b1;
                    w_freq_ok_d    = within_tol(r_cnt0_q, c_EXP0_V, c_TOL_V) &&
                                     within_tol(r_cnt1_q, c_EXP1_V, c_TOL_V);
`ifdef CPU_CLKMON_RATIO_CHECK_EN
                    w_ratio_ok_d   = ratio_within(r_cnt0_q, r_cnt1_q);
`endif
                    w_cnt0_d       = '0;
                    w_cnt1_d       = '0;
                    w_state_d      = MEASURE;
                end
            end
            default: begin
                w_state_d = WAIT_LOCK;
            end
        endcase

        // Lock loss: verdicts forced low, counts kept, set beats clear_err.
        if (w_abort) begin
            w_state_d     = WAIT_LOCK;
            w_phase_d     = '0;
            w_cnt0_d      = '0;
            w_cnt1_d      = '0;
            w_freq_ok_d   = 1'b0;
            w_lock_lost_d = 1'b1;
`ifdef CPU_CLKMON_RATIO_CHECK_EN
            w_ratio_ok_d  = 1'b0;
`endif
        end

        w_measuring_d = (w_state_d == SETTLE) || (w_state_d == MEASURE);
    end

    always_ff @(posedge refclk) begin
        if (rst) begin
            r_lock_s1_q    <= 1'b0;
            r_lock_s2_q    <= 1'b0;
            r_state_q      <= WAIT_LOCK;
            r_phase_q      <= '0;
            r_cnt0_q       <= '0;
            r_cnt1_q       <= '0;
            r_count0_q     <= '0;
            r_count1_q     <= '0;
            r_meas_valid_q <= 1'b0;
            r_freq_ok_q    <= 1'b0;
            r_lock_lost_q  <= 1'b0;
            r_measuring_q  <= 1'b0;
        end else begin
            r_lock_s1_q    <= w_lock_s1_d;
            r_lock_s2_q    <= w_lock_s2_d;
            r_state_q      <= w_state_d;
            r_phase_q      <= w_phase_d;
            r_cnt0_q       <= w_cnt0_d;
            r_cnt1_q       <= w_cnt1_d;
            r_count0_q     <= w_count0_d;
            r_count1_q     <= w_count1_d;
            r_meas_valid_q <= w_meas_valid_d;
            r_freq_ok_q    <= w_freq_ok_d;
            r_lock_lost_q  <= w_lock_lost_d;
            r_measuring_q  <= w_measuring_d;
        end
    end

`ifdef CPU_CLKMON_RATIO_CHECK_EN
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_ratio_ok_q <= 1'b0;
        end else begin
            r_ratio_ok_q <= w_ratio_ok_d;
        end
    end

    assign ratio_ok = r_ratio_ok_q;
`else
    assign ratio_ok = 1'b1;
`endif

    assign count0     = r_count0_q;
    assign count1     = r_count1_q;
    assign meas_valid = r_meas_valid_q;
    assign freq_ok    = r_freq_ok_q;
    assign lock_lost  = r_lock_lost_q;
    assign measuring  = r_measuring_q;

endmodule : cpu_clock_monitor
`default_nettype wire

// File: tb/tb_cpu_clock_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu_clock_monitor
// Description : Directed self-checking bench for cpu_clock_monitor with a
//               1000-cycle window, 8-cycle settle, EXP0=83, EXP1=250, TOL=2.
//               Input clocks are generated as integer multiples of refclk so
//               the expected edge counts are exact.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu_clock_monitor;

    localparam int W  = 1000;
    localparam int S  = 8;
    localparam int E0 = 83;
    localparam int E1 = 250;
    localparam int T  = 2;

`ifdef CPU_CLKMON_RATIO_CHECK_EN
    localparam logic RATIO_EN = 1'b1;
`else
    localparam logic RATIO_EN = 1'b0;
`endif
    // ratio_ok after a failing ratio, a lock loss or a reset.
    localparam logic RATIO_LOW = RATIO_EN ? 1'b0 : 1'b1;

    logic        refclk;
    logic        rst;
    logic        clk0_in;
    logic        clk1_in;
    logic        locked_in;
    logic        clear_err;
    logic [15:0] count0;
    logic [15:0] count1;
    logic        meas_valid;
    logic        freq_ok;
    logic        ratio_ok;
    logic        lock_lost;
    logic        measuring;

    int checks = 0;
    int errors = 0;

    // Input clock periods in refclk cycles (0 = stuck low).
    int p0 = 12;
    int p1 = 4;
    int c0 = 0;
    int c1 = 0;

    cpu_clock_monitor #(
        .WINDOW_CYCLES (W),
        .SETTLE_CYCLES (S),
        .EXP0          (E0),
        .EXP1          (E1),
        .TOL           (T)
    ) dut (
        .refclk     (refclk),
        .rst        (rst),
        .clk0_in    (clk0_in),
        .clk1_in    (clk1_in),
        .locked_in  (locked_in),
        .clear_err  (clear_err),
        .count0     (count0),
        .count1     (count1),
        .meas_valid (meas_valid),
        .freq_ok    (freq_ok),
        .ratio_ok   (ratio_ok),
        .lock_lost  (lock_lost),
        .measuring  (measuring)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    initial begin
        clk0_in = 1'b0;
        clk1_in = 1'b0;
        forever begin
            @(negedge refclk);
            c0 = c0 + 1;
            c1 = c1 + 1;
            clk0_in = (p0 == 0) ? 1'b0 : ((c0 % p0) < (p0 / 2));
            clk1_in = (p1 == 0) ? 1'b0 : ((c1 % p1) < (p1 / 2));
        end
    end

    task automatic wait_mv(input int max_cycles, output int n, output bit found);
        n = 0;
        found = 1'b0;
        while (!found && n < max_cycles) begin
            @(negedge refclk);
            n = n + 1;
            if (meas_valid === 1'b1) found = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; locked_in = 1'b0; clear_err = 1'b0;
        repeat (3) @(negedge refclk);
        checks++; if (count0 !== 16'd0)    begin errors++; $display("FAIL reset_count0: got %0d expected 0", count0); end
        checks++; if (count1 !== 16'd0)    begin errors++; $display("FAIL reset_count1: got %0d expected 0", count1); end
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_meas_valid: got %b expected 0", meas_valid); end
        checks++; if (freq_ok !== 1'b0)    begin errors++; $display("FAIL reset_freq_ok: got %b expected 0", freq_ok); end
        checks++; if (ratio_ok !== RATIO_LOW) begin errors++; $display("FAIL reset_ratio_ok: got %b expected %b", ratio_ok, RATIO_LOW); end
        checks++; if (lock_lost !== 1'b0)  begin errors++; $display("FAIL reset_lock_lost: got %b expected 0", lock_lost); end
        checks++; if (measuring !== 1'b0)  begin errors++; $display("FAIL reset_measuring: got %b expected 0", measuring); end
        rst = 1'b0;
        // Lock low while waiting must not start anything or flag loss.
        repeat (10) @(negedge refclk);
        checks++; if (measuring !== 1'b0 || lock_lost !== 1'b0) begin
            errors++; $display("FAIL wait_lock_idle: measuring=%b lock_lost=%b expected 0/0", measuring, lock_lost);
        end
    endtask

    task automatic test_first_window();
        int n; bit found;
        p0 = 12; p1 = 4;
        repeat (10) @(negedge refclk);
        locked_in = 1'b1;
        wait_mv(3000, n, found);
        checks++; if (!found || n < W + S + 2 || n > W + S + 4) begin
            errors++; $display("FAIL first_latency: got %0d found=%b expected %0d..%0d", n, found, W + S + 2, W + S + 4);
        end
        checks++; if (count0 !== 16'd83 && count0 !== 16'd84) begin errors++; $display("FAIL first_count0: got %0d expected 83 or 84", count0); end
        checks++; if (count1 !== 16'd250) begin errors++; $display("FAIL first_count1: got %0d expected 250", count1); end
        checks++; if (freq_ok !== 1'b1)   begin errors++; $display("FAIL first_freq_ok: got %b expected 1", freq_ok); end
        checks++; if (ratio_ok !== 1'b1)  begin errors++; $display("FAIL first_ratio_ok: got %b expected 1", ratio_ok); end
        checks++; if (measuring !== 1'b1) begin errors++; $display("FAIL first_measuring: got %b expected 1", measuring); end
        @(negedge refclk);
        checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL first_pulse_width: got %b expected 0", meas_valid); end
    endtask

    task automatic test_bad_ratio();
        int n; bit found;
        p1 = 5;
        wait_mv(3000, n, found);
        wait_mv(3000, n, found);
        checks++; if (!found) begin errors++; $display("FAIL ratio_timeout: got none expected meas_valid"); end
        checks++; if (count1 !== 16'd200) begin errors++; $display("FAIL ratio_count1: got %0d expected 200", count1); end
        checks++; if (count0 !== 16'd83 && count0 !== 16'd84) begin errors++; $display("FAIL ratio_count0: got %0d expected 83 or 84", count0); end
        checks++; if (freq_ok !== 1'b0)   begin errors++; $display("FAIL ratio_freq_ok: got %b expected 0", freq_ok); end
        checks++; if (ratio_ok !== RATIO_LOW) begin errors++; $display("FAIL ratio_ratio_ok: got %b expected %b", ratio_ok, RATIO_LOW); end
    endtask

    task automatic test_back_to_back();
        int n; bit found;
        p1 = 4;
        wait_mv(3000, n, found);
        wait_mv(3000, n, found);
        checks++; if (!found || n !== W + 1) begin errors++; $display("FAIL b2b_period: got %0d expected %0d", n, W + 1); end
        checks++; if (count1 !== 16'd250 || freq_ok !== 1'b1) begin
            errors++; $display("FAIL b2b_result: count1=%0d freq_ok=%b expected 250/1", count1, freq_ok);
        end
        // clk0 stuck low: the second full window sees no edges.
        p0 = 0;
        wait_mv(3000, n, found);
        wait_mv(3000, n, found);
        checks++; if (count0 !== 16'd0)  begin errors++; $display("FAIL stuck_count0: got %0d expected 0", count0); end
        checks++; if (freq_ok !== 1'b0)  begin errors++; $display("FAIL stuck_freq_ok: got %b expected 0", freq_ok); end
        checks++; if (count1 !== 16'd250) begin errors++; $display("FAIL stuck_count1: got %0d expected 250", count1); end
        p0 = 12;
        wait_mv(3000, n, found);
        wait_mv(3000, n, found);
        checks++; if (freq_ok !== 1'b1) begin errors++; $display("FAIL recover_freq_ok: got %b expected 1", freq_ok); end
    endtask

    task automatic test_lock_drop();
        int n; bit found;
        repeat (500) @(negedge refclk);
        locked_in = 1'b0;
        repeat (3) @(negedge refclk);
        checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL drop_lock_lost: got %b expected 1", lock_lost); end
        checks++; if (freq_ok !== 1'b0)   begin errors++; $display("FAIL drop_freq_ok: got %b expected 0", freq_ok); end
        checks++; if (ratio_ok !== RATIO_LOW) begin errors++; $display("FAIL drop_ratio_ok: got %b expected %b", ratio_ok, RATIO_LOW); end
        checks++; if (count1 !== 16'd250) begin errors++; $display("FAIL drop_count1_kept: got %0d expected 250", count1); end
        checks++; if (count0 !== 16'd83 && count0 !== 16'd84) begin errors++; $display("FAIL drop_count0_kept: got %0d expected 83 or 84", count0); end
        checks++; if (measuring !== 1'b0) begin errors++; $display("FAIL drop_measuring: got %b expected 0", measuring); end
        locked_in = 1'b1;
        wait_mv(3000, n, found);
        checks++; if (!found || n < W + S + 2 || n > W + S + 4) begin
            errors++; $display("FAIL relock_latency: got %0d found=%b expected %0d..%0d", n, found, W + S + 2, W + S + 4);
        end
        checks++; if (freq_ok !== 1'b1 || lock_lost !== 1'b1) begin
            errors++; $display("FAIL relock_flags: freq_ok=%b lock_lost=%b expected 1/1", freq_ok, lock_lost);
        end
    endtask

    task automatic test_reset_mid();
        repeat (300) @(negedge refclk);
        rst = 1'b1;
        @(negedge refclk);
        checks++; if (count0 !== 16'd0 || count1 !== 16'd0) begin
            errors++; $display("FAIL rstmid_counts: got %0d/%0d expected 0/0", count0, count1);
        end
        checks++; if (freq_ok !== 1'b0 || lock_lost !== 1'b0 || meas_valid !== 1'b0) begin
            errors++; $display("FAIL rstmid_flags: freq_ok=%b lock_lost=%b meas_valid=%b expected 0/0/0", freq_ok, lock_lost, meas_valid);
        end
        checks++; if (ratio_ok !== RATIO_LOW) begin errors++; $display("FAIL rstmid_ratio_ok: got %b expected %b", ratio_ok, RATIO_LOW); end
        checks++; if (measuring !== 1'b0) begin errors++; $display("FAIL rstmid_measuring: got %b expected 0", measuring); end
        rst = 1'b0;
        repeat (2) @(negedge refclk);
        checks++; if (measuring !== 1'b0) begin errors++; $display("FAIL restart_early: got %b expected 0", measuring); end
        @(negedge refclk);
        checks++; if (measuring !== 1'b1) begin errors++; $display("FAIL restart_settle: got %b expected 1", measuring); end
    endtask

    task automatic test_clear_err();
        repeat (20) @(negedge refclk);
        // clear_err lands in the same cycle the synchronised lock drop is seen.
        locked_in = 1'b0;
        repeat (2) @(negedge refclk);
        clear_err = 1'b1;
        @(negedge refclk);
        clear_err = 1'b0;
        checks++; if (lock_lost !== 1'b1) begin errors++; $display("FAIL clear_vs_set: got %b expected 1", lock_lost); end
        locked_in = 1'b1;
        repeat (6) @(negedge refclk);
        checks++; if (lock_lost !== 1'b1 || measuring !== 1'b1) begin
            errors++; $display("FAIL sticky_after_relock: lock_lost=%b measuring=%b expected 1/1", lock_lost, measuring);
        end
        clear_err = 1'b1;
        @(negedge refclk);
        clear_err = 1'b0;
        checks++; if (lock_lost !== 1'b0) begin errors++; $display("FAIL clear_alone: got %b expected 0", lock_lost); end
    endtask

    initial begin
        rst = 1'b1;
        locked_in = 1'b0;
        clear_err = 1'b0;
        test_reset();
        test_first_window();
        test_bad_ratio();
        test_back_to_back();
        test_lock_drop();
        test_reset_mid();
        test_clear_err();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_cpu_clock_monitor
`default_nettype wire
